// File: rtl/alu_md_if.sv
// rtl/alu_md_if.sv - operand, opcode, result and mul/div handshake bundle for alu_md
//
// Signals: A, B, f, start (master -> slave); s, overFlow, zero, busy, done, hi, lo (slave -> master).
// master modport: the EX stage or bench driving operands; slave modport: alu_md.
interface alu_md_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       f;
    logic             start;
    logic [WIDTH-1:0] s;
    logic             overFlow;
    logic             zero;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output A, B, f, start,
        input  s, overFlow, zero, busy, done, hi, lo
    );

    modport slave (
        input  A, B, f, start,
        output s, overFlow, zero, busy, done, hi, lo
    );
endinterface

// File: rtl/alu_md.sv
// rtl/alu_md.sv - combinational ALU plus sequential multiply/divide engine with HI/LO
//
// Ports: clk, rst_n (async active-low); bus (alu_md_if.slave): A, B, f, start in;
//        s, overFlow, zero (combinational), busy, done, hi, lo (registered) out.
// Build option: ALU_DIV_EN compiles in the restoring divider; without it DIV/DIVU
//        complete in one cycle and leave hi/lo untouched.
module alu_md #(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_md_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi;     // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
    logic             div_q;      // latched op is a divide
    logic             neg_q;      // product / quotient must be negated at FIN
    logic             neg_r;      // remainder must be negated at FIN
    logic             raw_q;      // FIN writes acc unmodified (divide by zero)
    logic             keep_q;     // FIN leaves hi/lo alone (divider not built)
    logic             busy_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    // ---------------- combinational ALU ----------------
    logic [WIDTH-1:0] sum, diff;
    logic             slt, sltu;

    assign sum  = bus.A + bus.B;
    assign diff = bus.A - bus.B;
    assign slt  = $signed(bus.A) < $signed(bus.B);
    assign sltu = bus.A < bus.B;

    always_comb begin
        bus.s        = '0;
        bus.overFlow = 1'b0;
        case (bus.f)
            4'b0000: bus.s = bus.A & bus.B;
            4'b0001: bus.s = bus.A | bus.B;
            4'b0010: begin
                bus.s        = sum;
                bus.overFlow = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                               (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0110: begin
                bus.s        = diff;
                bus.overFlow = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                               (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            4'b0111: bus.s = {{(WIDTH-1){1'b0}}, slt};
            4'b0011: bus.s = bus.A ^ bus.B;
            4'b0100: bus.s = ~(bus.A | bus.B);
            4'b0101: bus.s = {{(WIDTH-1){1'b0}}, sltu};
            4'b1100: bus.s = hi_q;
            4'b1101: bus.s = lo_q;
            default: bus.s = '0;
        endcase
    end

    assign bus.zero = (bus.s == '0);
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // ---------------- launch decode ----------------
    logic             launch, op_signed, op_div, short_path;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign launch    = (state == IDLE) && bus.start && (bus.f[3:2] == 2'b10);
    assign op_signed = ~bus.f[0];
    assign op_div    = bus.f[1];
    assign a_mag     = (op_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign b_mag     = (op_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // Divides that skip the iterative phase and go straight to FIN.
`ifdef ALU_DIV_EN
    assign short_path = op_div && (bus.B == '0);
`else
    assign short_path = op_div;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (launch) state_nxt = short_path ? FIN : RUN;
            RUN:  if (cnt == 1) state_nxt = FIN;
            FIN:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- iteration steps ----------------
    logic [WIDTH:0]   mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

`ifdef ALU_DIV_EN
    // Restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor when it fits. The remainder stays below the divisor,
    // so the trial difference always fits in WIDTH bits.
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_trial;
    logic             div_fits;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_fits  = div_shift >= {1'b0, opnd};
    assign div_trial = div_shift[WIDTH-1:0] - opnd;
`endif

    // ---------------- FIN sign correction ----------------
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0]   fin_hi, fin_lo;
    assign prod     = {acc_hi, acc_lo};
    assign prod_neg = -prod;

    always_comb begin
        fin_hi = acc_hi;
        fin_lo = acc_lo;
        if (raw_q) begin
            fin_hi = acc_hi;
            fin_lo = acc_lo;
        end else if (div_q) begin
            fin_lo = neg_q ? -acc_lo : acc_lo;
            fin_hi = neg_r ? -acc_hi : acc_hi;
        end else if (neg_q) begin
            {fin_hi, fin_lo} = prod_neg;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            raw_q  <= 1'b0;
            keep_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= (state == FIN);
            case (state)
                IDLE: begin
                    if (launch) begin
                        cnt    <= CW'(WIDTH);
                        acc_hi <= '0;
                        acc_lo <= a_mag;
                        opnd   <= b_mag;
                        div_q  <= op_div;
                        neg_q  <= op_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_r  <= op_signed && bus.A[WIDTH-1];
                        raw_q  <= 1'b0;
                        keep_q <= 1'b0;
`ifdef ALU_DIV_EN
                        if (short_path) begin
                            acc_hi <= bus.A;
                            acc_lo <= '1;
                            raw_q  <= 1'b1;
                        end
`else
                        keep_q <= short_path;
`endif
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
`ifdef ALU_DIV_EN
                    if (div_q) begin
                        acc_hi <= div_fits ? div_trial : div_shift[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], div_fits};
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
`else
                    acc_hi <= mul_sum[WIDTH:1];
                    acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
`endif
                end
                FIN: begin
                    if (!keep_q) begin
                        hi_q <= fin_hi;
                        lo_q <= fin_lo;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
